// File: rtl/peripheral_noc_vchannel_buffer.sv
// Multi-virtual-channel flit buffer: per-channel FIFOs behind one shared input,
// drained by a round-robin wormhole arbiter onto one shared output.
module peripheral_noc_vchannel_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 8,
    parameter int FULLPACKET = 0,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_WIDTH-1:0]        in_flit,
    input  logic                         in_last,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready,
    output logic [CHANNELS*(AW+1)-1:0]   fill_level
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "peripheral_noc_vchannel_buffer: DEPTH must be a power of two");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [CHANNELS-1:0]   wr_sel;
    logic [CHANNELS-1:0]   wr_en;
    logic [CHANNELS-1:0]   rd_en;
    logic [CHANNELS-1:0]   elig;
    logic [AW:0]           count [CHANNELS];
    logic [FLIT_WIDTH:0]   head  [CHANNELS];

    // Illegal multi-hot in_valid collapses to its lowest set bit.
    assign wr_sel = in_valid & (~in_valid + CHANNELS'(1));
    assign wr_en  = wr_sel & in_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [AW:0]       cnt_q;
        logic              has_pkt;
        logic [FLIT_WIDTH:0] mem [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // always_ff reads pre-edge values regardless of evaluation order.
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt_q  <= '0;
            end else begin
                if (wr_en[c]) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_en[c]) rd_ptr <= rd_ptr + PTR_ONE;
                if (wr_en[c] && !rd_en[c])
                    cnt_q <= cnt_q + CNT_ONE;
                else if (rd_en[c] && !wr_en[c])
                    cnt_q <= cnt_q - CNT_ONE;
            end
        end

        // NOTE: the flit RAM has no reset; stale entries are never visible because
        // count gates every read.
        always_ff @(posedge clk) begin
            if (wr_en[c]) mem[wr_ptr] <= {in_last, in_flit};
        end

        if (FULLPACKET != 0) begin : g_pkt
            logic [AW:0] pkt_q;
            logic        pkt_inc;
            logic        pkt_dec;

            assign pkt_inc = wr_en[c] && in_last;
            assign pkt_dec = rd_en[c] && head[c][FLIT_WIDTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    pkt_q <= '0;
                else if (pkt_inc && !pkt_dec)
                    pkt_q <= pkt_q + CNT_ONE;
                else if (pkt_dec && !pkt_inc)
                    pkt_q <= pkt_q - CNT_ONE;
            end

            assign has_pkt = (pkt_q != '0);
        end else begin : g_no_pkt
            assign has_pkt = 1'b1;
        end

        assign head[c]     = mem[rd_ptr];
        assign count[c]    = cnt_q;
        assign elig[c]     = (cnt_q != '0) && has_pkt;
        assign in_ready[c] = (cnt_q != DEPTH_C) && !rst;
        assign fill_level[c*(AW+1) +: (AW+1)] = cnt_q;
    end

    state_t        state_q, state_d;
    logic [CW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cand;
    logic          cand_vld;
    logic [CW-1:0] sel;
    logic          present;
    logic          xfer;

    // Round-robin search starting just after the last channel that finished a packet.
    always_comb begin
        logic [CW-1:0] idx;
        cand     = '0;
        cand_vld = 1'b0;
        idx      = ptr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (idx == LAST_CH) ? '0 : idx + CW'(1);
            if (!cand_vld && elig[idx]) begin
                cand     = idx;
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        sel       = (state_q == LOCKED) ? gnt_q : cand;
        present   = (state_q == LOCKED) ? (count[gnt_q] != '0) : cand_vld;
        out_valid = present ? (CHANNELS'(1) << sel) : '0;
        out_flit  = present ? head[sel][FLIT_WIDTH-1:0] : '0;
        out_last  = present ? head[sel][FLIT_WIDTH] : 1'b0;
        rd_en     = out_valid & out_ready;
        xfer      = (rd_en != '0);

        case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    if (xfer && out_last) begin
                        ptr_d = cand;
                    end else begin
                        state_d = LOCKED;
                        gnt_d   = cand;
                    end
                end
            end
            LOCKED: begin
                if (xfer && out_last) begin
                    state_d = IDLE;
                    ptr_d   = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= LAST_CH;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_peripheral_noc_vchannel_buffer.sv
// Scoreboard bench for peripheral_noc_vchannel_buffer: a normal instance and a
// FULLPACKET instance, each with its own expected-flit queue and monitor.
module tb_peripheral_noc_vchannel_buffer;

    localparam int FW = 32;
    localparam int CH = 2;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [FW-1:0]          in_flit;
    logic                   in_last;
    logic [CH-1:0]          in_valid, in_valid_fp;
    logic [CH-1:0]          in_ready, in_ready_fp;
    logic [FW-1:0]          out_flit, out_flit_fp;
    logic                   out_last, out_last_fp;
    logic [CH-1:0]          out_valid, out_valid_fp;
    logic [CH-1:0]          out_ready, out_ready_fp;
    logic [CH*(AW+1)-1:0]   fill_level, fill_level_fp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CH-1:0] vld;
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_fp_q[$];

    peripheral_noc_vchannel_buffer #(
        .FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(8), .FULLPACKET(0)
    ) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .fill_level(fill_level)
    );

    peripheral_noc_vchannel_buffer #(
        .FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(8), .FULLPACKET(1)
    ) dut_fp (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
        .in_valid(in_valid_fp), .in_ready(in_ready_fp), .out_flit(out_flit_fp),
        .out_last(out_last_fp), .out_valid(out_valid_fp), .out_ready(out_ready_fp),
        .fill_level(fill_level_fp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [AW:0] fill_of(input logic [CH*(AW+1)-1:0] fl, input int ch);
        return fl[ch*(AW+1) +: (AW+1)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit fp, input int ch, input logic [FW-1:0] f, input logic l);
        exp_t e;
        e.vld  = CH'(1) << ch;
        e.flit = f;
        e.last = l;
        if (fp) exp_fp_q.push_back(e);
        else    exp_q.push_back(e);
    endtask

    task automatic wr(input bit fp, input int ch, input logic [FW-1:0] f, input logic l);
        in_flit = f;
        in_last = l;
        if (fp) in_valid_fp = CH'(1) << ch;
        else    in_valid    = CH'(1) << ch;
        tick();
        in_valid    = '0;
        in_valid_fp = '0;
    endtask

    task automatic wait_drain(input bit fp);
        for (int i = 0; i < 40; i++) begin
            if ((fp ? fill_level_fp : fill_level) == '0) break;
            tick();
        end
        check(fp ? "drain_fp" : "drain", 64'(fp ? fill_level_fp : fill_level), 64'(0));
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (out_valid & out_ready) != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_valid", 64'(out_valid), 64'(e.vld));
                check("sb_flit",  64'(out_flit),  64'(e.flit));
                check("sb_last",  64'(out_last),  64'(e.last));
            end
        end
    end

    always @(negedge clk) begin : mon_fp
        exp_t e;
        if (!rst && (out_valid_fp & out_ready_fp) != '0) begin
            if (exp_fp_q.size() == 0) begin
                check("sb_fp_unexpected", 64'(out_valid_fp), 64'(0));
            end else begin
                e = exp_fp_q.pop_front();
                check("sb_fp_valid", 64'(out_valid_fp), 64'(e.vld));
                check("sb_fp_flit",  64'(out_flit_fp),  64'(e.flit));
                check("sb_fp_last",  64'(out_last_fp),  64'(e.last));
            end
        end
    end

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [CH-1:0] wv [7];
    logic [FW-1:0] wf [7];

    initial begin
        in_flit = '0; in_last = 1'b0; in_valid = '0; in_valid_fp = '0;
        out_ready = '0; out_ready_fp = '0;
        wv = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        wf = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h12, 32'h12, 32'hC0};

        // Reset state
        #3;
        check("rst_in_ready",  64'(in_ready),   64'(0));
        check("rst_out_valid", 64'(out_valid),  64'(0));
        check("rst_out_flit",  64'(out_flit),   64'(0));
        check("rst_out_last",  64'(out_last),   64'(0));
        check("rst_fill",      64'(fill_level), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rel_in_ready",    64'(in_ready),    64'(2'b11));
        check("rel_in_ready_fp", 64'(in_ready_fp), 64'(2'b11));

        // Fill channel 0 to capacity, then drain
        for (int i = 1; i <= 8; i++) begin
            push(0, 0, FW'(i), (i == 8));
            wr(0, 0, FW'(i), (i == 8));
        end
        check("full_in_ready0", 64'(in_ready[0]), 64'(0));
        check("full_in_ready1", 64'(in_ready[1]), 64'(1));
        check("full_fill0",     64'(fill_of(fill_level, 0)), 64'(8));
        wr(0, 0, 32'h9, 1'b1);
        check("full_drop_fill0", 64'(fill_of(fill_level, 0)), 64'(8));
        out_ready = 2'b10;
        tick();
        check("foreign_ready_fill0", 64'(fill_of(fill_level, 0)), 64'(8));
        out_ready = 2'b01;
        check("fill_head", 64'(out_flit), 64'(1));
        tick();
        check("ready_after_read", 64'(in_ready[0]), 64'(1));
        check("fill_after_read",  64'(fill_of(fill_level, 0)), 64'(7));
        wait_drain(0);
        out_ready = '0;

        // Round-robin between two pending single-flit packets
        push(0, 0, 32'hA0, 1'b1);
        push(0, 1, 32'hB0, 1'b1);
        wr(0, 0, 32'hA0, 1'b1);
        wr(0, 1, 32'hB0, 1'b1);
        out_ready = 2'b11;
        check("rr_valid0", 64'(out_valid), 64'(2'b01));
        check("rr_flit0",  64'(out_flit),  64'(32'hA0));
        tick();
        check("rr_valid1", 64'(out_valid), 64'(2'b10));
        check("rr_flit1",  64'(out_flit),  64'(32'hB0));
        tick();
        check("rr_idle", 64'(out_valid), 64'(0));
        out_ready = '0;

        // Wormhole lock with toggling out_ready
        push(0, 0, 32'h10, 1'b0);
        push(0, 0, 32'h11, 1'b0);
        push(0, 0, 32'h12, 1'b1);
        push(0, 1, 32'hC0, 1'b1);
        wr(0, 0, 32'h10, 1'b0);
        wr(0, 0, 32'h11, 1'b0);
        wr(0, 0, 32'h12, 1'b1);
        wr(0, 1, 32'hC0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            out_ready = (k % 2 == 1 && k < 6) ? 2'b11 : 2'b00;
            #1;
            check($sformatf("wh_valid%0d", k), 64'(out_valid), 64'(wv[k]));
            check($sformatf("wh_flit%0d", k),  64'(out_flit),  64'(wf[k]));
            tick();
        end
        out_ready = 2'b10;
        tick();
        check("wh_done", 64'(out_valid), 64'(0));
        out_ready = '0;

        // Backpressure stability while channel 1 is granted
        push(0, 1, 32'hD0, 1'b0);
        push(0, 1, 32'hD1, 1'b1);
        push(0, 0, 32'hE0, 1'b1);
        wr(0, 1, 32'hD0, 1'b0);
        wr(0, 1, 32'hD1, 1'b1);
        wr(0, 0, 32'hE0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid%0d", k), 64'(out_valid), 64'(2'b10));
            check($sformatf("bp_flit%0d", k),  64'(out_flit),  64'(32'hD0));
            check($sformatf("bp_last%0d", k),  64'(out_last),  64'(0));
            tick();
        end
        out_ready = 2'b11;
        wait_drain(0);
        out_ready = '0;

        // FULLPACKET: channel held back until its tail is stored
        out_ready_fp = 2'b11;
        push(1, 1, 32'h20, 1'b0);
        push(1, 1, 32'h21, 1'b0);
        push(1, 1, 32'h22, 1'b1);
        wr(1, 1, 32'h20, 1'b0);
        check("fp_wait0", 64'(out_valid_fp), 64'(0));
        wr(1, 1, 32'h21, 1'b0);
        check("fp_wait1", 64'(out_valid_fp), 64'(0));
        wr(1, 1, 32'h22, 1'b1);
        check("fp_elig_valid", 64'(out_valid_fp), 64'(2'b10));
        check("fp_elig_flit",  64'(out_flit_fp),  64'(32'h20));
        wait_drain(1);
        check("fp_idle", 64'(out_valid_fp), 64'(0));
        out_ready_fp = '0;

        // Asynchronous reset in the middle of a packet
        push(0, 0, 32'h30, 1'b0);
        wr(0, 0, 32'h30, 1'b0);
        wr(0, 0, 32'h31, 1'b0);
        wr(0, 0, 32'h32, 1'b1);
        out_ready = 2'b01;
        check("pre_rst_head", 64'(out_flit), 64'(32'h30));
        tick();
        out_ready = '0;
        check("mid_pkt_flit", 64'(out_flit), 64'(32'h31));
        #2 rst = 1'b1;
        #1;
        check("arst_valid",    64'(out_valid),  64'(0));
        check("arst_flit",     64'(out_flit),   64'(0));
        check("arst_last",     64'(out_last),   64'(0));
        check("arst_fill",     64'(fill_level), 64'(0));
        check("arst_in_ready", 64'(in_ready),   64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_rel_ready", 64'(in_ready), 64'(2'b11));
        out_ready = 2'b11;
        push(0, 0, 32'h40, 1'b1);
        push(0, 1, 32'h41, 1'b1);
        wr(0, 0, 32'h40, 1'b1);
        check("post_rst_valid", 64'(out_valid), 64'(2'b01));
        check("post_rst_flit",  64'(out_flit),  64'(32'h40));
        wr(0, 1, 32'h41, 1'b1);
        wait_drain(0);
        out_ready = '0;
        tick();

        check("sb_left",    64'(exp_q.size()),    64'(0));
        check("sb_fp_left", 64'(exp_fp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
